// File: rtl/fp_convert_seq.sv
// fp_convert_seq: multi-cycle 12-bit two's-complement to (S, E[2:0], F[3:0])
// floating-point converter, value = F * 2^E. One serial normalizing shift per
// cycle, round-half-up with significand carry and exponent saturation.
module fp_convert_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] D,
  output logic        busy,
  output logic        done,
  output logic        S,
  output logic [2:0]  E,
  output logic [3:0]  F
);

  typedef enum logic [1:0] {
    IDLE,
    MAG,
    NORM,
    ROUND
  } state_t;

  state_t      state;
  logic [11:0] d_reg;
  logic        sgn;
  // Magnitude never exceeds 12'h7FF, so bit 11 would always be zero;
  // 11 bits hold the whole normalization window.
  logic [10:0] mag;
  logic [2:0]  exp_r;

  logic [11:0] d_neg;
  logic [3:0]  f_cut;
  logic        fifth;
  logic [3:0]  f_rnd;
  logic [2:0]  e_rnd;

  // Two's-complement negation of the captured sample
  always_comb begin
    d_neg = ~d_reg + 12'd1;
  end

  // Round-half-up on the 4-bit window with carry-out and saturation
  always_comb begin
    f_cut = mag[10:7];
    fifth = mag[6];
    f_rnd = f_cut;
    e_rnd = exp_r;
    if (fifth) begin
      if (f_cut != 4'b1111) begin
        f_rnd = f_cut + 4'd1;
      end else if (exp_r != 3'd7) begin
        f_rnd = 4'b1000;
        e_rnd = exp_r + 3'd1;
      end else begin
        f_rnd = 4'b1111;
        e_rnd = 3'b111;
      end
    end
  end

  // Conversion sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      d_reg <= '0;
      sgn   <= 1'b0;
      mag   <= '0;
      exp_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= 1'b0;
      E     <= '0;
      F     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            d_reg <= D;
            busy  <= 1'b1;
            state <= MAG;
          end
        end
        MAG: begin
          sgn <= d_reg[11];
          // -2048 has no positive 12-bit counterpart; clamp to the largest magnitude
          if (d_reg == 12'h800) begin
            mag <= 11'h7FF;
          end else if (d_reg[11]) begin
            mag <= d_neg[10:0];
          end else begin
            mag <= d_reg[10:0];
          end
          exp_r <= 3'd7;
          state <= NORM;
        end
        NORM: begin
          if (mag[10] || exp_r == 3'd0) begin
            state <= ROUND;
          end else begin
            mag   <= {mag[9:0], 1'b0};
            exp_r <= exp_r - 3'd1;
          end
        end
        ROUND: begin
          F     <= f_rnd;
          E     <= e_rnd;
          S     <= sgn;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_seq.sv
// Directed testbench for fp_convert_seq: hand-computed conversion results,
// latency, busy/done behaviour, ignored restart, back-to-back and async reset.
module tb_fp_convert_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] D;
  logic        busy;
  logic        done;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;

  int checks;
  int errors;

  fp_convert_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .D     (D),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .E     (E),
    .F     (F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present D with start, then drop start #1 after the accepting edge (edge 0)
  task automatic drive_start(input logic [11:0] d);
    D     = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; check latency, busy, and result fields
  task automatic wait_done(input string tag, input int exp_edge,
                           input logic s_exp, input logic [2:0] e_exp,
                           input logic [3:0] f_exp);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) found = 1'b1;
      else      check({tag, "_busy_mid"}, {15'd0, busy}, 16'd1);
    end
    check({tag, "_done_seen"}, {15'd0, found}, 16'd1);
    check({tag, "_latency"}, 16'(n), 16'(exp_edge));
    check({tag, "_busy_end"}, {15'd0, busy}, 16'd0);
    check({tag, "_S"}, {15'd0, S}, {15'd0, s_exp});
    check({tag, "_E"}, {13'd0, E}, {13'd0, e_exp});
    check({tag, "_F"}, {12'd0, F}, {12'd0, f_exp});
  endtask

  task automatic done_drops(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
  endtask

  task automatic convert(input string tag, input logic [11:0] d, input int exp_edge,
                         input logic s_exp, input logic [2:0] e_exp, input logic [3:0] f_exp);
    @(negedge clk);
    drive_start(d);
    check({tag, "_busy_start"}, {15'd0, busy}, 16'd1);
    wait_done(tag, exp_edge, s_exp, e_exp, f_exp);
    done_drops(tag);
  endtask

  initial begin
    int  seen_done;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    D      = '0;
    #12;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_SEF", {8'd0, S, E, F}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // n=2: 422 -> 13 * 2^5
    convert("d422", 12'd422, 5, 1'b0, 3'd5, 4'd13);
    // result held while idle
    repeat (3) @(posedge clk);
    #1;
    check("hold_SEF", {8'd0, S, E, F}, {8'd0, 1'b0, 3'd5, 4'd13});
    check("hold_busy", {15'd0, busy}, 16'd0);

    convert("dm422", 12'hE5A, 5, 1'b1, 3'd5, 4'd13);
    // round up, n=5
    convert("d46", 12'd46, 8, 1'b0, 3'd2, 4'd12);
    // significand carry into exponent
    convert("d1020", 12'd1020, 4, 1'b0, 3'd7, 4'd8);
    // exponent saturation
    convert("d7ff", 12'h7FF, 3, 1'b0, 3'd7, 4'd15);
    convert("d800", 12'h800, 3, 1'b1, 3'd7, 4'd15);
    convert("dm1", 12'hFFF, 10, 1'b1, 3'd0, 4'd1);
    convert("d0", 12'd0, 10, 1'b0, 3'd0, 4'd0);

    // start re-pulsed while busy with a different D is ignored
    @(negedge clk);
    drive_start(12'd422);
    @(posedge clk);
    #1;
    D     = 12'd46;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", 3, 1'b0, 3'd5, 4'd13);
    done_drops("ign");
    repeat (12) @(posedge clk);
    #1;
    check("ign_no_restart", {15'd0, busy}, 16'd0);
    check("ign_result", {8'd0, S, E, F}, {8'd0, 1'b0, 3'd5, 4'd13});

    // back-to-back: start asserted in the done cycle is accepted
    @(negedge clk);
    drive_start(12'd46);
    wait_done("b2b_a", 8, 1'b0, 3'd2, 4'd12);
    D     = 12'hE5A;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_done_drop", {15'd0, done}, 16'd0);
    check("b2b_busy", {15'd0, busy}, 16'd1);
    wait_done("b2b_b", 5, 1'b1, 3'd5, 4'd13);
    done_drops("b2b_b");

    // asynchronous reset during NORM aborts without a done pulse
    @(negedge clk);
    drive_start(12'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {15'd0, busy}, 16'd0);
    check("arst_done", {15'd0, done}, 16'd0);
    check("arst_SEF", {8'd0, S, E, F}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    check("arst_no_done", 16'(seen_done), 16'd0);
    convert("post_rst", 12'd422, 5, 1'b0, 3'd5, 4'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
